// File: rtl/ttl_seq_pkg.sv
// Shared types for the T-state sequencer: state encoding and the
// decoder enable triple driven in each state.
package ttl_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_HALTED
    } seq_state_e;

    typedef struct packed {
        logic e1_bar;
        logic e2_bar;
        logic e3;
    } en_t;

    localparam en_t EN_RUN  = en_t'{e1_bar: 1'b0, e2_bar: 1'b0, e3: 1'b1};
    localparam en_t EN_HOLD = en_t'{e1_bar: 1'b0, e2_bar: 1'b1, e3: 1'b1};
    localparam en_t EN_OFF  = en_t'{e1_bar: 1'b1, e2_bar: 1'b1, e3: 1'b0};

    function automatic en_t en_of(input seq_state_e st);
        unique case (st)
            ST_RUN:  return EN_RUN;
            ST_HOLD: return EN_HOLD;
            default: return EN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/ttl_seq_watchdog.sv
// Counts consecutive HOLD cycles; requests a forced halt at the limit
// and keeps a sticky trip flag until reset.
module ttl_seq_watchdog
    import ttl_seq_pkg::*;
#(
    parameter int WDOG_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hold_i,
    output logic expire_o,
    output logic trip_o
);

    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          trip_q, trip_d;

    always_comb begin
        expire_o = hold_i && (cnt_q == LIMIT);
        cnt_d    = hold_i ? cnt_q + 1'b1 : '0;
        trip_d   = trip_q | expire_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            trip_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trip_q <= trip_d;
        end
    end

    assign trip_o = trip_q;

endmodule

// File: rtl/ttl_step_sequencer.sv
// Microcode T-state sequencer driving a 3-to-8 decoder (step + enables).
// Optional stall watchdog: define SEQ_WATCHDOG_EN.
module ttl_step_sequencer
    import ttl_seq_pkg::*;
#(
    parameter int STEPS       = 8,
    parameter int WIDTH_IN    = $clog2(STEPS),
    parameter int DELAY_RISE  = 12,
    parameter int DELAY_FALL  = 12,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Stall,
    input  logic                EndSeq,
    input  logic                Halt,
    output logic [WIDTH_IN-1:0] Step,
    output logic                Enable1_bar,
    output logic                Enable2_bar,
    output logic                Enable3,
    output logic                Busy,
    output logic                Done,
    output logic                WdogTrip
);

    localparam logic [WIDTH_IN-1:0] LAST = WIDTH_IN'(STEPS - 1);

    // Output delays are board-level timing only; the logic is zero-delay.
    if (STEPS < 2 || STEPS > (1 << WIDTH_IN) || DELAY_RISE < 0 ||
        DELAY_FALL < 0 || WDOG_CYCLES < 1) begin : g_bad_param
        $fatal(1, "ttl_step_sequencer: illegal parameter set");
    end

    seq_state_e          state_q, state_d;
    logic [WIDTH_IN-1:0] step_q, step_d;
    en_t                 en_q;
    logic                busy_q, done_q, done_d;
    logic                wdog_expire;

`ifdef SEQ_WATCHDOG_EN
    ttl_seq_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .hold_i  (state_q == ST_HOLD),
        .expire_o(wdog_expire),
        .trip_o  (WdogTrip)
    );
`else
    assign wdog_expire = 1'b0;
    assign WdogTrip    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_HALTED;
                end else if (Stall) begin
                    state_d = ST_HOLD;
                end else if (EndSeq || step_q == LAST) begin
                    step_d  = '0;
                    done_d  = 1'b1;
                    state_d = Start ? ST_RUN : ST_IDLE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (Halt || wdog_expire) begin
                    state_d = ST_HALTED;
                end else if (!Stall) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            en_q    <= EN_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            en_q    <= en_of(state_d);
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_HOLD);
            done_q  <= done_d;
        end
    end

    assign Step        = step_q;
    assign Enable1_bar = en_q.e1_bar;
    assign Enable2_bar = en_q.e2_bar;
    assign Enable3     = en_q.e3;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_ttl_step_sequencer.sv
// Directed scoreboard bench: STEPS=8 and STEPS=5 instances, shared clock.
// Watchdog expectations follow SEQ_WATCHDOG_EN.
module tb_ttl_step_sequencer;

    typedef struct packed {
        logic [2:0] step;
        logic       e1b;
        logic       e2b;
        logic       e3;
        logic       busy;
        logic       done;
        logic       wdog;
    } exp_t;

    localparam int IDL = 0;
    localparam int RN  = 1;
    localparam int HLD = 2;

`ifdef SEQ_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, stall = 1'b0;
    logic       endseq = 1'b0, halt = 1'b0;
    logic [2:0] step;
    logic       e1b, e2b, e3, busy, done, wdog;

    logic       rst5 = 1'b1, start5 = 1'b0, zero = 1'b0;
    logic [2:0] step5;
    logic       e1b5, e2b5, e35, busy5, done5, wdog5;

    exp_t q8[$];
    exp_t q5[$];
    int   total = 0;
    int   bad = 0;

    ttl_step_sequencer #(.STEPS(8), .WDOG_CYCLES(4)) dut8 (
        .Clk(clk), .Reset(rst), .Start(start), .Stall(stall),
        .EndSeq(endseq), .Halt(halt), .Step(step),
        .Enable1_bar(e1b), .Enable2_bar(e2b), .Enable3(e3),
        .Busy(busy), .Done(done), .WdogTrip(wdog)
    );

    ttl_step_sequencer #(.STEPS(5), .WDOG_CYCLES(4)) dut5 (
        .Clk(clk), .Reset(rst5), .Start(start5), .Stall(zero),
        .EndSeq(zero), .Halt(zero), .Step(step5),
        .Enable1_bar(e1b5), .Enable2_bar(e2b5), .Enable3(e35),
        .Busy(busy5), .Done(done5), .WdogTrip(wdog5)
    );

    function automatic exp_t ex(input int mode, input int s,
                                input logic d, input logic w);
        exp_t e;
        e.step = 3'(s);
        e.e1b  = (mode == IDL);
        e.e2b  = (mode != RN);
        e.e3   = (mode != IDL);
        e.busy = (mode != IDL);
        e.done = d;
        e.wdog = w;
        return e;
    endfunction

    task automatic tick(input string tag, input exp_t e);
        exp_t got, want;
        q8.push_back(e);
        @(posedge clk);
        #1;
        got  = {step, e1b, e2b, e3, busy, done, wdog};
        want = q8.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got step=%0d e=%b%b%b busy=%b done=%b wdog=%b want step=%0d e=%b%b%b busy=%b done=%b wdog=%b",
                   tag, got.step, got.e1b, got.e2b, got.e3, got.busy, got.done, got.wdog,
                   want.step, want.e1b, want.e2b, want.e3, want.busy, want.done, want.wdog);
        end
    endtask

    task automatic tick5(input string tag, input exp_t e);
        exp_t got, want;
        q5.push_back(e);
        @(posedge clk);
        #1;
        got  = {step5, e1b5, e2b5, e35, busy5, done5, wdog5};
        want = q5.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got step=%0d e=%b%b%b busy=%b done=%b wdog=%b want step=%0d e=%b%b%b busy=%b done=%b wdog=%b",
                   tag, got.step, got.e1b, got.e2b, got.e3, got.busy, got.done, got.wdog,
                   want.step, want.e1b, want.e2b, want.e3, want.busy, want.done, want.wdog);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        tick("reset0", ex(IDL, 0, 0, 0));
        tick("reset1", ex(IDL, 0, 0, 0));
        rst = 1'b0;
        tick("idle_hold", ex(IDL, 0, 0, 0));

        // full sequence 0..7, Done, back to IDLE
        start = 1'b1;
        tick("seq_s0", ex(RN, 0, 0, 0));
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick("seq_run", ex(RN, i, 0, 0));
        tick("seq_done", ex(IDL, 0, 1, 0));
        tick("seq_idle", ex(IDL, 0, 0, 0));

        // early EndSeq at step 3 with Start -> stays RUN
        start = 1'b1;
        tick("es_s0", ex(RN, 0, 0, 0));
        start = 1'b0;
        for (int i = 1; i < 4; i++) tick("es_run", ex(RN, i, 0, 0));
        endseq = 1'b1;
        start  = 1'b1;
        tick("es_b2b", ex(RN, 0, 1, 0));
        endseq = 1'b0;
        start  = 1'b0;
        tick("es_s1", ex(RN, 1, 0, 0));
        tick("es_s2", ex(RN, 2, 0, 0));

        // stall at step 2 for 3 cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick("stall_hold", ex(HLD, 2, 0, 0));
        stall = 1'b0;
        tick("stall_rel", ex(RN, 2, 0, 0));
        tick("stall_s3", ex(RN, 3, 0, 0));
        tick("run_s4", ex(RN, 4, 0, 0));
        tick("run_s5", ex(RN, 5, 0, 0));

        // halt at step 5; everything but reset ignored
        halt = 1'b1;
        tick("halt", ex(IDL, 5, 0, 0));
        halt  = 1'b0;
        start = 1'b1;
        tick("halt_start", ex(IDL, 5, 0, 0));
        stall  = 1'b1;
        endseq = 1'b1;
        tick("halt_misc", ex(IDL, 5, 0, 0));
        start  = 1'b0;
        stall  = 1'b0;
        endseq = 1'b0;
        rst    = 1'b1;
        tick("halt_reset", ex(IDL, 0, 0, 0));
        rst = 1'b0;

        // natural wrap at 7 with Start held -> back-to-back
        start = 1'b1;
        tick("wrap_s0", ex(RN, 0, 0, 0));
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick("wrap_run", ex(RN, i, 0, 0));
        start = 1'b1;
        tick("wrap_b2b", ex(RN, 0, 1, 0));
        start = 1'b0;

        // halt from HOLD
        stall = 1'b1;
        tick("hh_hold", ex(HLD, 0, 0, 0));
        halt = 1'b1;
        tick("hh_halt", ex(IDL, 0, 0, 0));
        halt  = 1'b0;
        stall = 1'b0;
        rst   = 1'b1;
        tick("hh_reset", ex(IDL, 0, 0, 0));
        rst = 1'b0;

        // watchdog: stall held from step 0
        start = 1'b1;
        tick("wd_s0", ex(RN, 0, 0, 0));
        start = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (WDOG && i >= 4) tick("wd_trip", ex(IDL, 0, 0, 1));
            else tick("wd_hold", ex(HLD, 0, 0, 0));
        end
        stall = 1'b0;
        rst   = 1'b1;
        tick("wd_reset", ex(IDL, 0, 0, 0));
        rst = 1'b0;

        // STEPS=5: reset mid-sequence, then wrap 4 -> 0
        rst5 = 1'b0;
        start5 = 1'b1;
        tick5("s5_s0", ex(RN, 0, 0, 0));
        start5 = 1'b0;
        for (int i = 1; i < 4; i++) tick5("s5_run", ex(RN, i, 0, 0));
        rst5 = 1'b1;
        tick5("s5_abort", ex(IDL, 0, 0, 0));
        rst5 = 1'b0;
        tick5("s5_idle", ex(IDL, 0, 0, 0));
        start5 = 1'b1;
        tick5("s5_r0", ex(RN, 0, 0, 0));
        start5 = 1'b0;
        for (int i = 1; i < 5; i++) tick5("s5_rrun", ex(RN, i, 0, 0));
        tick5("s5_wrap", ex(IDL, 0, 1, 0));
        tick5("s5_end", ex(IDL, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
